// File: rtl/mealy_batch_if.sv
// Handshake bundle between the start/ack side and the mealy_batch controller.
interface mealy_batch_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   go;
    logic [COUNT_WIDTH-1:0] count;
    logic                   ack;
    logic                   en;
    logic                   done;
    logic                   busy;
    logic                   timeout;
    logic [COUNT_WIDTH-1:0] iter;

    // Requester side: software start register plus datapath acknowledge.
    modport master (
        output go, count, ack,
        input  en, done, busy, timeout, iter
    );

    // Controller side.
    modport slave (
        input  go, count, ack,
        output en, done, busy, timeout, iter
    );
endinterface

// File: rtl/mealy_batch.sv
// Batch go/ack controller: issues `count` enable/ack transactions per start,
// with a Mealy done on the final ack and an optional per-transaction timeout.
module mealy_batch #(
    parameter int COUNT_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 0
) (
    input logic          clk,
    input logic          rst,
    mealy_batch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE, ERROR} state_e;

    localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);
    localparam logic [15:0]            TO_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0
                                                 : 16'(TIMEOUT_CYCLES - 1);
    localparam bit                     TO_EN   = (TIMEOUT_CYCLES != 0);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] iter_q, iter_d;
    logic [15:0]            wait_q, wait_d;
    logic                   last;

    // cnt_q >= 1 whenever ISSUE is live, so the subtraction never wraps there.
    assign last = (iter_q == cnt_q - ONE);

    // State and counter registers; reset drops everything back to IDLE at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            iter_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic; ack takes priority over an expiring timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        iter_d  = iter_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (bus.go) begin
                    cnt_d   = bus.count;
                    iter_d  = '0;
                    wait_d  = '0;
                    state_d = (bus.count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (bus.ack) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        iter_d = iter_q + ONE;
                        wait_d = '0;
                    end
                end else begin
                    // Saturate so a disabled timeout can stall forever harmlessly.
                    wait_d = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
                    if (TO_EN && wait_q == TO_LAST) state_d = ERROR;
                end
            end
            DONE:    if (!bus.go) state_d = IDLE;
            ERROR:   if (!bus.go) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state; done alone looks at ack in ISSUE.
    always_comb begin
        bus.en      = (state_q == ISSUE);
        bus.busy    = (state_q == ISSUE);
        bus.timeout = (state_q == ERROR);
        bus.done    = (state_q == DONE) || ((state_q == ISSUE) && bus.ack && last);
        bus.iter    = iter_q;
    end
endmodule

// File: tb/tb_mealy_batch.sv
// Bench for mealy_batch: two instances (timeout off / timeout 4), batch-level
// reference model feeding per-DUT handshake scoreboards.
module tb_mealy_batch;
    localparam int CW = 8;
    localparam int T1 = 4;

    typedef struct {
        int iter;
        bit done;
    } hs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mealy_batch_if #(.COUNT_WIDTH(CW)) if0 ();
    mealy_batch_if #(.COUNT_WIDTH(CW)) if1 ();

    mealy_batch #(.COUNT_WIDTH(CW), .TIMEOUT_CYCLES(0))  dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    mealy_batch #(.COUNT_WIDTH(CW), .TIMEOUT_CYCLES(T1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // Stimulus goes to the selected instance; the other one sees go=0/ack=0.
    logic          sel = 1'b0;
    logic          go_s = 1'b0;
    logic [CW-1:0] count_s = '0;
    logic          ack_s = 1'b0;

    assign if0.go    = sel ? 1'b0 : go_s;
    assign if0.count = count_s;
    assign if0.ack   = sel ? 1'b0 : ack_s;
    assign if1.go    = sel ? go_s : 1'b0;
    assign if1.count = count_s;
    assign if1.ack   = sel ? ack_s : 1'b0;

    logic          s_en, s_done, s_busy, s_to;
    logic [CW-1:0] s_iter;
    assign s_en   = sel ? if1.en      : if0.en;
    assign s_done = sel ? if1.done    : if0.done;
    assign s_busy = sel ? if1.busy    : if0.busy;
    assign s_to   = sel ? if1.timeout : if0.timeout;
    assign s_iter = sel ? if1.iter    : if0.iter;

    int   total = 0;
    int   bad = 0;
    int   en_seen = 0;
    hs_t  q0[$];
    hs_t  q1[$];
    int   gq[$];
    hs_t  e0, e1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every accepted handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (s_en) en_seen++;
        if (if0.en && if0.ack) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL hs0_unexpected: got iter %0d expected no handshake", if0.iter);
            end else begin
                e0 = q0.pop_front();
                chk("hs0_iter", 32'(if0.iter), 32'(e0.iter));
                chk("hs0_done", 32'(if0.done), 32'(e0.done));
                chk("hs0_busy", 32'(if0.busy), 32'd1);
            end
        end
        if (if1.en && if1.ack) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL hs1_unexpected: got iter %0d expected no handshake", if1.iter);
            end else begin
                e1 = q1.pop_front();
                chk("hs1_iter", 32'(if1.iter), 32'(e1.iter));
                chk("hs1_done", 32'(if1.done), 32'(e1.done));
                chk("hs1_busy", 32'(if1.busy), 32'd1);
            end
        end
    end

    // One batch: gq[i] = idle (ack low) cycles before transaction i is acked.
    task automatic run_batch(input int n, input int hold);
        int t;
        int stall;
        int exp_en;
        int n_run;
        hs_t h;
        t = sel ? T1 : 0;
        stall = -1;
        exp_en = 0;
        // Batch-level model: a gap of at least T ack-low cycles stalls the batch.
        for (int i = 0; i < n; i++) begin
            if (t != 0 && gq[i] >= t) begin
                stall = i;
                exp_en += t;
                break;
            end
            h.iter = i;
            h.done = (i == n - 1);
            if (sel) q1.push_back(h); else q0.push_back(h);
            exp_en += gq[i] + 1;
        end
        n_run = (stall >= 0) ? stall : n;

        en_seen = 0;
        go_s = 1'b1; count_s = CW'(n); ack_s = 1'b0;
        @(posedge clk); #1;
        chk("start_en", 32'(s_en), 32'(n != 0));
        if (n == 0) chk("zero_done", 32'(s_done), 32'd1);
        for (int i = 0; i < n_run; i++) begin
            repeat (gq[i]) begin @(posedge clk); #1; end
            ack_s = 1'b1;
            @(posedge clk); #1;
            ack_s = 1'b0;
        end
        if (stall >= 0) repeat (t) begin @(posedge clk); #1; end
        chk("batch_en_cycles", 32'(en_seen), 32'(exp_en));
        for (int c = 0; c <= hold; c++) begin
            chk("term_en", 32'(s_en), 32'd0);
            chk("term_busy", 32'(s_busy), 32'd0);
            chk("term_done", 32'(s_done), 32'(stall < 0));
            chk("term_timeout", 32'(s_to), 32'(stall >= 0));
            chk("term_iter", 32'(s_iter), 32'((stall >= 0) ? stall : ((n == 0) ? 0 : n - 1)));
            if (c < hold) begin @(posedge clk); #1; end
        end
        go_s = 1'b0;
        @(posedge clk); #1;
        chk("idle_done", 32'(s_done), 32'd0);
        chk("idle_timeout", 32'(s_to), 32'd0);
        chk("idle_en", 32'(s_en), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

    initial begin
        // Reset held with go=1: nothing may start.
        go_s = 1'b1; count_s = 8'd3; ack_s = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("rst_en", 32'(s_en), 32'd0);
            chk("rst_done", 32'(s_done), 32'd0);
            chk("rst_busy", 32'(s_busy), 32'd0);
            chk("rst_timeout", 32'(s_to), 32'd0);
            chk("rst_iter", 32'(s_iter), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;

        // count=3 with ack after 4 idle cycles each, then hold go 10 cycles.
        gq = '{4, 4, 4};
        run_batch(3, 10);
        // Back-to-back acks: exactly 5 ISSUE cycles.
        gq = '{0, 0, 0, 0, 0};
        run_batch(5, 0);
        // Empty batch.
        gq = '{};
        run_batch(0, 2);

        // Timeout instance: first transaction acked, second stalls.
        sel = 1'b1;
        gq = '{0, 9};
        run_batch(2, 1);
        sel = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a 10-long batch after 4 handshakes.
        for (int i = 0; i < 4; i++) q0.push_back('{iter: i, done: 1'b0});
        go_s = 1'b1; count_s = 8'd10; ack_s = 1'b1;
        @(posedge clk); #1;
        repeat (4) begin @(posedge clk); #1; end
        ack_s = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("midrst_en", 32'(s_en), 32'd0);
        chk("midrst_busy", 32'(s_busy), 32'd0);
        chk("midrst_done", 32'(s_done), 32'd0);
        chk("midrst_iter", 32'(s_iter), 32'd0);
        go_s = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        gq = '{2};
        run_batch(1, 0);

        // Randomized batches on the untimed instance.
        for (int b = 0; b < 20; b++) begin
            int n;
            n = int'($urandom_range(12, 0));
            gq = '{};
            for (int i = 0; i < n; i++)
                gq.push_back(($urandom_range(2, 0) == 0) ? 0 : int'($urandom_range(6, 0)));
            run_batch(n, int'($urandom_range(3, 0)));
        end
        // Randomized batches on the timeout instance.
        sel = 1'b1;
        @(posedge clk); #1;
        for (int b = 0; b < 20; b++) begin
            int n;
            n = int'($urandom_range(6, 1));
            gq = '{};
            for (int i = 0; i < n; i++) gq.push_back(int'($urandom_range(5, 0)));
            run_batch(n, int'($urandom_range(3, 0)));
        end

        repeat (2) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
